// File: rtl/vend_credit_ctrl.sv
// Coin credit / dispense controller with change refund and a multiplexed 7-segment credit display.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module vend_credit_ctrl #(
    parameter int                     NUM_COINS       = 4,
    parameter logic [8*NUM_COINS-1:0] COIN_VALS       = 32'h19_0A_05_01,
    parameter int                     CREDIT_W        = 8,
    parameter int                     PRICE           = 50,
    parameter int                     MAX_CREDIT      = 99,
    parameter int                     DISPENSE_CYCLES = 50000000,
    parameter int                     DIGITS          = 3,
    parameter int                     SCAN_DIV        = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] coin,
    input  logic                 cancel,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 dispense,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amt,
    output logic                 reject,
    output logic                 busy,
    output logic [6:0]           display,
    output logic [DIGITS-1:0]    enable
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COLLECT  = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_REFUND   = 2'd3;

    // The sum is one bit wider than both operands so the ceiling test sees any carry.
    localparam int SUM_W   = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
    localparam int TIMER_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SUM_W-1:0]   MAX_SUM    = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]   PRICE_SUM  = SUM_W'(PRICE);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DISPENSE_CYCLES - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [1:0]           state_q,    state_d;
    logic [CREDIT_W-1:0]  credit_q,   credit_d;
    logic [TIMER_W-1:0]   timer_q,    timer_d;
    logic                 reject_q,   reject_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]    enable_q,   enable_d;
    logic [6:0]           display_q,  display_d;

    logic                 coin_hit;
    logic [7:0]           coin_val;
    logic [SUM_W-1:0]     sum;
    logic [4*DIGITS-1:0]  bcd;
    logic [DIGITS-1:0]    blank;

    // Lowest-index coin wins: the descending loop lets lower channels overwrite higher ones.
    always_comb begin
        coin_hit = 1'b0;
        coin_val = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (coin[i]) begin
                coin_hit = 1'b1;
                coin_val = COIN_VALS[8*i +: 8];
            end
        end
    end

    assign sum = SUM_W'(credit_q) + SUM_W'(coin_val);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = timer_q;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if ((state_q == ST_COLLECT) && cancel) begin
                    state_d  = ST_REFUND;
                    reject_d = coin_hit;
                end else if (coin_hit) begin
                    if (sum > MAX_SUM) begin
                        reject_d = 1'b1;
                    end else if (sum >= PRICE_SUM) begin
                        credit_d = CREDIT_W'(sum - PRICE_SUM);
                        timer_d  = TIMER_LOAD;
                        state_d  = ST_DISPENSE;
                    end else begin
                        credit_d = CREDIT_W'(sum);
                        state_d  = ST_COLLECT;
                    end
                end
            end
            ST_DISPENSE: begin
                reject_d = coin_hit;
                if (timer_q == '0) begin
                    state_d = (credit_q != '0) ? ST_REFUND : ST_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_REFUND: begin
                reject_d = coin_hit;
                credit_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Double-dabble binary to BCD; digit 0 holds the ones.
    always_comb begin
        bcd = '0;
        for (int b = CREDIT_W - 1; b >= 0; b--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[4*DIGITS-2:0], credit_q[b]};
        end
    end

    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int d = DIGITS - 1; d >= 1; d--) begin
                lead     = lead && (bcd[4*d +: 4] == 4'd0);
                blank[d] = lead;
            end
        end
`endif
    end

    function automatic logic [6:0] seg7(input logic [3:0] v, input logic blank_i);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return blank_i ? 7'h7F : s;
    endfunction

    // Enable and segments are both built from the next index so they change on the same edge.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        enable_d  = ~(DIGITS'(1) << scan_idx_d);
        display_d = seg7(bcd[4*scan_idx_d +: 4], blank[scan_idx_d]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            timer_q    <= '0;
            reject_q   <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            enable_q   <= ~DIGITS'(1);
            display_q  <= 7'h7F;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            timer_q    <= timer_d;
            reject_q   <= reject_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            enable_q   <= enable_d;
            display_q  <= display_d;
        end
    end

    assign credit       = credit_q;
    assign dispense     = (state_q == ST_DISPENSE);
    assign change_valid = (state_q == ST_REFUND);
    assign change_amt   = change_valid ? credit_q : '0;
    assign busy         = (state_q == ST_DISPENSE) || (state_q == ST_REFUND);
    assign reject       = reject_q;
    assign display      = display_q;
    assign enable       = enable_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: one instance at PRICE=50, one at PRICE=99.
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] coin_a, coin_b;
    logic       cancel_a, cancel_b;

    logic [7:0] credit_a, change_amt_a, credit_b, change_amt_b;
    logic       dispense_a, change_valid_a, reject_a, busy_a;
    logic       dispense_b, change_valid_b, reject_b, busy_b;
    logic [6:0] display_a, display_b;
    logic [2:0] enable_a, enable_b;

    vend_credit_ctrl #(.PRICE(50), .DISPENSE_CYCLES(4), .SCAN_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .coin(coin_a), .cancel(cancel_a),
        .credit(credit_a), .dispense(dispense_a), .change_valid(change_valid_a),
        .change_amt(change_amt_a), .reject(reject_a), .busy(busy_a),
        .display(display_a), .enable(enable_a)
    );

    vend_credit_ctrl #(.PRICE(99), .DISPENSE_CYCLES(4), .SCAN_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .coin(coin_b), .cancel(cancel_b),
        .credit(credit_b), .dispense(dispense_b), .change_valid(change_valid_b),
        .change_amt(change_amt_b), .reject(reject_b), .busy(busy_b),
        .display(display_b), .enable(enable_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_reject_q[$];   // credit expected while the reject pulse is high
    int exp_change_q[$];   // expected refund amounts
    int exp_disp_q[$];     // expected dispense pulse lengths
    int disp_len = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (reject_a) begin
                if (exp_reject_q.size() == 0) check("unexpected_reject", 1, 0);
                else check("reject_credit", credit_a, exp_reject_q.pop_front());
            end
            if (change_valid_a) begin
                if (exp_change_q.size() == 0) check("unexpected_change", 1, 0);
                else check("change_amt", change_amt_a, exp_change_q.pop_front());
            end else if (change_amt_a != 8'd0) begin
                check("change_amt_idle", change_amt_a, 0);
            end
            if (busy_a !== (dispense_a || change_valid_a)) check("busy_decode", busy_a, dispense_a || change_valid_a);
            if (dispense_a) begin
                disp_len++;
            end else if (disp_len > 0) begin
                if (exp_disp_q.size() == 0) check("unexpected_dispense", 1, 0);
                else check("dispense_len", disp_len, exp_disp_q.pop_front());
                disp_len = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [3:0] c, input logic k);
        coin_a   = c;
        cancel_a = k;
        cyc();
        coin_a   = '0;
        cancel_a = 1'b0;
    endtask

    task automatic drive_b(input logic [3:0] c);
        coin_b = c;
        cyc();
        coin_b = '0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 30) begin
            cyc();
            n++;
        end
        check({tag, "_idle"}, busy_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_seg[3];
        int prev_idx, idx, run;
        bit run_started;

        reset = 1'b1;
        coin_a = '0; cancel_a = 1'b0;
        coin_b = '0; cancel_b = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;

        check("rst_credit", credit_a, 0);
        check("rst_dispense", dispense_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_reject", reject_a, 0);
        check("rst_change_valid", change_valid_a, 0);
        check("rst_change_amt", change_amt_a, 0);
        check("rst_enable", enable_a, 3'b110);
        check("rst_credit_b", credit_b, 0);

        // 25 + 25 reaches the price exactly: no change
        drive_a(4'b1000, 1'b0);
        check("t1_credit25", credit_a, 25);
        cyc();
        exp_disp_q.push_back(4);
        drive_a(4'b1000, 1'b0);
        check("t1_credit0", credit_a, 0);
        check("t1_dispense", dispense_a, 1);
        wait_idle_a("t1");
        check("t1_credit_end", credit_a, 0);

        // a coin arriving during dispense is refused
        drive_a(4'b1000, 1'b0);
        cyc();
        exp_disp_q.push_back(4);
        drive_a(4'b1000, 1'b0);
        cyc();
        exp_reject_q.push_back(0);
        drive_a(4'b0100, 1'b0);
        check("t2_credit", credit_a, 0);
        wait_idle_a("t2");

        // simultaneous coins: lowest channel (5) taken, no reject
        drive_a(4'b1010, 1'b0);
        check("t3_multi_credit", credit_a, 5);
        exp_change_q.push_back(5);
        drive_a(4'b0000, 1'b1);
        check("t3_refund", change_valid_a, 1);
        cyc();
        check("t3_credit_end", credit_a, 0);

        // cancel in IDLE ignored; coin with cancel in IDLE accepted
        drive_a(4'b0000, 1'b1);
        check("t4_cancel_idle", busy_a, 0);
        drive_a(4'b0001, 1'b1);
        check("t4_coin_cancel_idle", credit_a, 1);
        check("t4_not_busy", busy_a, 0);
        exp_change_q.push_back(1);
        drive_a(4'b0000, 1'b1);
        cyc();
        check("t4_credit_end", credit_a, 0);

        // credit 15 then cancel
        drive_a(4'b0100, 1'b0);
        drive_a(4'b0010, 1'b0);
        check("t5_credit15", credit_a, 15);
        exp_change_q.push_back(15);
        drive_a(4'b0000, 1'b1);
        check("t5_change_valid", change_valid_a, 1);
        check("t5_change_amt", change_amt_a, 15);
        cyc();
        check("t5_credit0", credit_a, 0);
        check("t5_idle", busy_a, 0);

        // 40 + 25 overshoots: dispense then refund 15
        drive_a(4'b1000, 1'b0);
        drive_a(4'b0100, 1'b0);
        drive_a(4'b0010, 1'b0);
        check("t6_credit40", credit_a, 40);
        exp_disp_q.push_back(4);
        exp_change_q.push_back(15);
        drive_a(4'b1000, 1'b0);
        check("t6_credit15", credit_a, 15);
        check("t6_dispense", dispense_a, 1);
        wait_idle_a("t6");
        check("t6_credit_end", credit_a, 0);

        // display scan at credit 15, then cancel and coin together
        drive_a(4'b0100, 1'b0);
        drive_a(4'b0010, 1'b0);
        cyc();
        exp_seg[0] = 7'h12;
        exp_seg[1] = 7'h79;
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg[2] = 7'h7F;
`else
        exp_seg[2] = 7'h40;
`endif
        prev_idx = -1;
        run = 0;
        run_started = 1'b0;
        for (int c = 0; c < 13; c++) begin
            case (enable_a)
                3'b110:  idx = 0;
                3'b101:  idx = 1;
                3'b011:  idx = 2;
                default: idx = -1;
            endcase
            check("scan_enable_onehot", (idx >= 0), 1);
            if (idx >= 0) begin
                check("scan_display", display_a, exp_seg[idx]);
                if (prev_idx >= 0 && idx != prev_idx) begin
                    check("scan_order", idx, (prev_idx + 1) % 3);
                    if (run_started) check("scan_dwell", run, 2);
                    run_started = 1'b1;
                    run = 1;
                end else begin
                    run++;
                end
                prev_idx = idx;
            end
            cyc();
        end
        exp_reject_q.push_back(15);
        exp_change_q.push_back(15);
        drive_a(4'b0010, 1'b1);
        check("t7_change_valid", change_valid_a, 1);
        check("t7_change_amt", change_amt_a, 15);
        cyc();
        check("t7_credit0", credit_a, 0);

        // ceiling test on the PRICE=99 instance
        repeat (3) drive_b(4'b1000);
        repeat (2) drive_b(4'b0100);
        repeat (2) drive_b(4'b0001);
        check("b_credit97", credit_b, 97);
        drive_b(4'b0100);
        check("b_reject_overflow", reject_b, 1);
        check("b_credit_held", credit_b, 97);
        drive_b(4'b0001);
        check("b_credit98", credit_b, 98);
        check("b_no_reject", reject_b, 0);
        drive_b(4'b0001);
        check("b_dispense_at_max", dispense_b, 1);
        check("b_credit_after", credit_b, 0);

        repeat (8) cyc();
        check("pending_reject", exp_reject_q.size(), 0);
        check("pending_change", exp_change_q.size(), 0);
        check("pending_dispense", exp_disp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
